// File: rtl/vproc_pkg.sv
// Shared type definitions for the vector processor DIV unit.
package vproc_pkg;

    typedef enum logic [1:0] {
        DIV_VDIVU,
        DIV_VDIV,
        DIV_VREMU,
        DIV_VREM
    } opcode_div;

    typedef enum logic {
        DIV_GENERIC
    } div_type;

    typedef enum logic [1:0] {
        VSEW_8,
        VSEW_16,
        VSEW_32,
        VSEW_INVALID
    } cfg_vsew;

endpackage

// File: rtl/vproc_div_fixup.sv
// Combinational operand preparation (sign extension, magnitude, special cases)
// and result sign correction / truncation for the element divider.
module vproc_div_fixup
    import vproc_pkg::*;
(
    input  opcode_div   in_op,
    input  cfg_vsew     in_sew,
    input  logic [31:0] in_dividend,
    input  logic [31:0] in_divisor,
    output logic [31:0] dvd_aligned,
    output logic [31:0] dvs_mag,
    output logic [4:0]  cnt_init,
    output logic        dvd_neg,
    output logic        dvs_neg,
    output logic        special,
    output logic [31:0] special_result,
    input  opcode_div   res_op,
    input  cfg_vsew     res_sew,
    input  logic        res_dvd_neg,
    input  logic        res_dvs_neg,
    input  logic [31:0] res_quot,
    input  logic [31:0] res_rem,
    output logic [31:0] result
);

    function automatic logic [31:0] sew_mask(input cfg_vsew sew);
        case (sew)
            VSEW_8:  return 32'h0000_00FF;
            VSEW_16: return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] sew_msb(input cfg_vsew sew);
        case (sew)
            VSEW_8:  return 32'h0000_0080;
            VSEW_16: return 32'h0000_8000;
            default: return 32'h8000_0000;
        endcase
    endfunction

    function automatic logic op_signed(input opcode_div op);
        return (op == DIV_VDIV) || (op == DIV_VREM);
    endfunction

    function automatic logic op_div(input opcode_div op);
        return (op == DIV_VDIVU) || (op == DIV_VDIV);
    endfunction

    logic [31:0] mask, msb, dvd_w, dvs_w, dvd_ext, dvs_ext, dvd_abs;
    logic        sgn, div0, ovf;
    logic [31:0] rmask, q_fix, r_fix;

    always_comb begin
        mask    = sew_mask(in_sew);
        msb     = sew_msb(in_sew);
        dvd_w   = in_dividend & mask;
        dvs_w   = in_divisor & mask;
        sgn     = op_signed(in_op);
        dvd_neg = sgn && ((dvd_w & msb) != '0);
        dvs_neg = sgn && ((dvs_w & msb) != '0);
        dvd_ext = dvd_neg ? (dvd_w | ~mask) : dvd_w;
        dvs_ext = dvs_neg ? (dvs_w | ~mask) : dvs_w;
        dvd_abs = dvd_neg ? -dvd_ext : dvd_ext;
        dvs_mag = dvs_neg ? -dvs_ext : dvs_ext;

        // Left-align the dividend so the iteration always shifts out of bit 31.
        case (in_sew)
            VSEW_8: begin
                dvd_aligned = dvd_abs << 24;
                cnt_init    = 5'd7;
            end
            VSEW_16: begin
                dvd_aligned = dvd_abs << 16;
                cnt_init    = 5'd15;
            end
            default: begin
                dvd_aligned = dvd_abs;
                cnt_init    = 5'd31;
            end
        endcase

        div0    = (dvs_w == '0);
        ovf     = sgn && (dvd_w == msb) && (dvs_w == mask);
        special = div0 || ovf;
        if (div0) begin
            special_result = op_div(in_op) ? mask : dvd_w;
        end else if (ovf) begin
            special_result = op_div(in_op) ? dvd_w : '0;
        end else begin
            special_result = '0;
        end
    end

    always_comb begin
        rmask  = sew_mask(res_sew);
        q_fix  = (op_signed(res_op) && (res_dvd_neg != res_dvs_neg)) ? -res_quot : res_quot;
        r_fix  = (op_signed(res_op) && res_dvd_neg) ? -res_rem : res_rem;
        result = (op_div(res_op) ? q_fix : r_fix) & rmask;
    end

endmodule

// File: rtl/vproc_div_elem.sv
// Iterative single-element restoring divider (one quotient bit per cycle)
// with RISC-V V quotient/remainder semantics.
module vproc_div_elem
    import vproc_pkg::*;
#(
    parameter int unsigned TAG_W    = 4,
    parameter div_type     DIV_TYPE = DIV_GENERIC
) (
    input  logic             clk_i,
    input  logic             async_rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  opcode_div        in_op_i,
    input  cfg_vsew          in_sew_i,
    input  logic [31:0]      in_dividend_i,
    input  logic [31:0]      in_divisor_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_result_o,
    output logic [TAG_W-1:0] out_tag_o
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state;

    div_state         state_q, state_d;
    opcode_div        op_q;
    cfg_vsew          sew_q;
    logic [TAG_W-1:0] tag_q;
    logic             dvd_neg_q, dvs_neg_q;
    logic [31:0]      dvs_q, shreg_q, rem_q, result_q;
    logic [4:0]       cnt_q;

    logic [31:0] dvd_aligned, dvs_mag, special_result, fix_result;
    logic [4:0]  cnt_init;
    logic        dvd_neg, dvs_neg, special, accept;

    logic [32:0] rem_shift, diff;
    logic [31:0] rem_nxt, shreg_nxt;

    if (DIV_TYPE == DIV_GENERIC) begin : g_generic
        vproc_div_fixup u_fixup (
            .in_op          (in_op_i),
            .in_sew         (in_sew_i),
            .in_dividend    (in_dividend_i),
            .in_divisor     (in_divisor_i),
            .dvd_aligned    (dvd_aligned),
            .dvs_mag        (dvs_mag),
            .cnt_init       (cnt_init),
            .dvd_neg        (dvd_neg),
            .dvs_neg        (dvs_neg),
            .special        (special),
            .special_result (special_result),
            .res_op         (op_q),
            .res_sew        (sew_q),
            .res_dvd_neg    (dvd_neg_q),
            .res_dvs_neg    (dvs_neg_q),
            .res_quot       (shreg_nxt),
            .res_rem        (rem_nxt),
            .result         (fix_result)
        );
    end

    assign accept = (state_q == IDLE) && in_valid_i && !flush_i;

    always_comb begin
        rem_shift = {rem_q, shreg_q[31]};
        diff      = rem_shift - {1'b0, dvs_q};
        if (diff[32]) begin
            rem_nxt   = rem_shift[31:0];
            shreg_nxt = {shreg_q[30:0], 1'b0};
        end else begin
            rem_nxt   = diff[31:0];
            shreg_nxt = {shreg_q[30:0], 1'b1};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_q   <= IDLE;
            op_q      <= DIV_VDIVU;
            sew_q     <= VSEW_8;
            tag_q     <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            dvs_q     <= '0;
            shreg_q   <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q      <= in_op_i;
                sew_q     <= in_sew_i;
                tag_q     <= in_tag_i;
                dvd_neg_q <= dvd_neg;
                dvs_neg_q <= dvs_neg;
                dvs_q     <= dvs_mag;
                shreg_q   <= dvd_aligned;
                rem_q     <= '0;
                cnt_q     <= cnt_init;
                if (special) result_q <= special_result;
            end else if (state_q == CALC && !flush_i) begin
                shreg_q <= shreg_nxt;
                rem_q   <= rem_nxt;
                cnt_q   <= cnt_q - 5'd1;
                if (cnt_q == '0) result_q <= fix_result;
            end
        end
    end

    assign in_ready_o   = (state_q == IDLE);
    assign out_valid_o  = (state_q == DONE);
    assign out_result_o = result_q;
    assign out_tag_o    = tag_q;

endmodule

// File: doc/vproc_div_elem.md
# vproc_div_elem

Iterative single-element integer divider for the vector DIV unit. It accepts one dividend/divisor pair per operation, selected by `opcode_div` and `cfg_vsew`, and returns a quotient or remainder with RISC-V V semantics. It sits between the DIV unit's operand-unpack stage and its result-pack stage. A DIV unit instantiates one or more of these per lane.

## Interface
- `TAG_W`, default 4: width of the opaque tag carried with each operation (element index / mask bit).
- `DIV_TYPE`, default `DIV_GENERIC`: implementation selector. Only `DIV_GENERIC` is defined.

Ports:
- `clk_i` in 1: clock.
- `async_rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: synchronous abort of any operation in flight.
- `in_valid_i` in 1: operation valid.
- `in_ready_o` out 1: divider can accept an operation.
- `in_op_i` in `opcode_div`: `DIV_VDIVU` / `DIV_VDIV` / `DIV_VREMU` / `DIV_VREM`.
- `in_sew_i` in `cfg_vsew`: element width, 8, 16 or 32. `VSEW_INVALID` is never presented.
- `in_dividend_i` in 32: vs2 element. Only the low SEW bits are used.
- `in_divisor_i` in 32: vs1 element or rs1. Only the low SEW bits are used.
- `in_tag_i` in `TAG_W`: passed through unchanged.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: consumer accepts the result.
- `out_result_o` out 32: SEW-bit result in the low bits. Bits above SEW are zero.
- `out_tag_o` out `TAG_W`: tag of the returned result.

## Operation
- State machine:
  - `IDLE`: `in_ready_o`=1. On `in_valid_i`, latch op, sew, tag and operands.
    - Special case: next state `DONE`.
    - Otherwise: next state `CALC`.
  - `CALC`: restoring radix-2 iteration, one quotient bit per cycle. A counter loads W−1 and decrements. On the cycle with count==0, load the sign-fixed result register and go to `DONE`.
  - `DONE`: `out_valid_o`=1. On `out_ready_i`, go to `IDLE`.
- W = 8/16/32 from SEW.
- Operands:
  - Operands are sign-extended from bit W−1 when the op is signed (`DIV_VDIV`, `DIV_VREM`).
  - Magnitudes are taken before iterating.
  - Iteration datapath: partial remainder of W+1 bits, quotient/dividend shift register of W bits.
- Sign fix:
  - Quotient is negated when the op is signed and the operand signs differ.
  - Remainder is negated when the op is signed and the dividend is negative.
- Special cases, detected at acceptance:
  - Divisor==0: quotient = all-ones (W bits); remainder = dividend.
  - Signed overflow, dividend = −2^(W−1) and divisor = −1: quotient = dividend; remainder = 0.
- Result is truncated to W bits. Upper 32−W bits are zero.
- `in_ready_o` is high only in `IDLE`. There is no overlap of operations.
- `flush_i` takes priority over all transitions. The next state is `IDLE` and the operation is dropped with no output.
- Async reset mid-operation: immediately `IDLE`, operation lost.
- Reset value of outputs:
  - `in_ready_o`=1.
  - `out_valid_o`=0.
  - `out_result_o`=0.
  - `out_tag_o`=0.

## Timing
- Acceptance is the cycle with `in_valid_i & in_ready_o`, counted as cycle 0.
- Normal path: `CALC` occupies cycles 1..W. `out_valid_o` rises in cycle W+1, i.e. 9, 17 or 33 cycles after acceptance.
- Special case: `out_valid_o` rises in cycle 1.
- `out_result_o` and `out_tag_o` are registered and stable while `out_valid_o`=1 and `out_ready_i`=0.
- Result handshake completes on `out_valid_o & out_ready_i`. `in_ready_o` is high in the following cycle. Minimum issue interval is W+2 cycles (normal) or 2 cycles (special case).
- No combinational path from `in_*` to `out_*`. `in_ready_o` depends on state only.
- Simultaneous `flush_i` and `in_valid_i` in `IDLE`: the input is not accepted.

## Structure
- Package `vproc_pkg`: already holds `opcode_div`, `div_type` and `cfg_vsew`. Add nothing else.
- Local enum: `div_state` {`IDLE`, `CALC`, `DONE`}.
- Natural sub-module: `vproc_div_fixup`, purely combinational. It performs:
  - special-case detection;
  - operand sign extension and magnitude on input;
  - sign correction and truncation on output.
- The iteration datapath stays in `vproc_div_elem`.

## Test plan
- SEW32, `DIV_VDIV`, −7 (0xFFFFFFF9) / 2 → 0xFFFFFFFD exactly 33 cycles after acceptance. The same operands with `DIV_VREM` → 0xFFFFFFFF.
- SEW8, `DIV_VDIVU`, 0x25 / 0 → 0x000000FF in cycle 1. `DIV_VREMU` with the same operands → 0x00000025.
- SEW16, `DIV_VDIV`, 0x8000 / 0xFFFF → 0x00008000. `DIV_VREM` → 0x00000000. Garbage in bits 31:16 of the inputs must be ignored.
- SEW8, `DIV_VDIVU`, 0xFF / 0x10 → 0x0F at cycle 9, with tag 0xA. Hold `out_ready_i`=0 for 5 cycles: result, tag and valid stay stable and `in_ready_o`=0.
- Back-to-back random ops for all SEW/op combinations, including 0, ±1, min and max values, checked against a reference model. Verify the issue interval is W+2.
- Assert `flush_i`, and separately `async_rst_ni`, in `CALC` cycle 5 → no `out_valid_o`, `in_ready_o`=1 next cycle. A new operation then completes correctly.
